// File: rtl/arb2_req_fifo.sv
// Two-client request queue feeding a 2-way round-robin arbiter; pops one head word per grant.
// Latency: push to req 1 cycle; grant to registered out_valid/out_data 1 cycle (one-cycle pulse).
// Backpressure: full1_o/full2_o flag a full FIFO; pushes while full are dropped and set sticky ovf_o.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   push{1,2}_i, din{1,2}_i per-client write strobe and data
//   full{1,2}_o, cnt{1,2}_o per-client full flag and occupancy (0..DEPTH)
//   req{1,2}_o, gnt{1,2}_i  request to / grant from the arbiter
//   out_valid_o, out_src_o, out_data_o  popped word (src 0 = client 1, 1 = client 2)
//   ovf_o, perr_o           sticky overflow and protocol-error flags
module arb2_req_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push1_i,
    input  logic [DW-1:0] din1_i,
    output logic          full1_o,
    input  logic          push2_i,
    input  logic [DW-1:0] din2_i,
    output logic          full2_o,
    output logic          req1_o,
    output logic          req2_o,
    input  logic          gnt1_i,
    input  logic          gnt2_i,
    output logic          out_valid_o,
    output logic          out_src_o,
    output logic [DW-1:0] out_data_o,
    output logic [CW-1:0] cnt1_o,
    output logic [CW-1:0] cnt2_o,
    output logic          ovf_o,
    output logic          perr_o
);

    logic [DW-1:0] mem1_q [DEPTH];
    logic [DW-1:0] mem2_q [DEPTH];

    logic [AW-1:0] rptr1_q, rptr1_d, wptr1_q, wptr1_d;
    logic [AW-1:0] rptr2_q, rptr2_d, wptr2_q, wptr2_d;
    logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic          out_valid_q, out_valid_d;
    logic          out_src_q, out_src_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          ovf_q, ovf_d;
    logic          perr_q, perr_d;

    logic req1, req2, full1, full2;
    logic pop1, pop2, wr1, wr2;

    always_comb begin
        // Flags come from the registered counts only, so no input reaches an output.
        req1  = (cnt1_q != '0);
        req2  = (cnt2_q != '0);
        full1 = (cnt1_q == CW'(DEPTH));
        full2 = (cnt2_q == CW'(DEPTH));

        // Client 1 has priority when both grants arrive together; client 2 is
        // never popped while gnt1 is asserted.
        pop1 = gnt1_i & req1;
        pop2 = gnt2_i & ~gnt1_i & req2;

        // Full is judged on the pre-edge count, so a same-edge pop does not
        // make room for a push into a full FIFO.
        wr1 = push1_i & ~full1;
        wr2 = push2_i & ~full2;

        rptr1_d = rptr1_q + AW'(pop1);
        rptr2_d = rptr2_q + AW'(pop2);
        wptr1_d = wptr1_q + AW'(wr1);
        wptr2_d = wptr2_q + AW'(wr2);
        cnt1_d  = cnt1_q + CW'(wr1) - CW'(pop1);
        cnt2_d  = cnt2_q + CW'(wr2) - CW'(pop2);

        ovf_d  = ovf_q | (push1_i & full1) | (push2_i & full2);
        perr_d = perr_q | (gnt1_i & ~req1) | (gnt2_i & ~req2) | (gnt1_i & gnt2_i);

        out_valid_d = pop1 | pop2;
        out_src_d   = out_src_q;
        out_data_d  = out_data_q;
        if (pop1) begin
            out_src_d  = 1'b0;
            out_data_d = mem1_q[rptr1_q];
        end else if (pop2) begin
            out_src_d  = 1'b1;
            out_data_d = mem2_q[rptr2_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr1_q     <= '0;
            wptr1_q     <= '0;
            rptr2_q     <= '0;
            wptr2_q     <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            rptr1_q     <= rptr1_d;
            wptr1_q     <= wptr1_d;
            rptr2_q     <= rptr2_d;
            wptr2_q     <= wptr2_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            perr_q      <= perr_d;
        end
    end

    // Storage is not reset: a write during reset lands in a slot that the
    // cleared pointers/counts treat as empty, so it is never observed.
    always_ff @(posedge clk_i) begin
        if (wr1) mem1_q[wptr1_q] <= din1_i;
        if (wr2) mem2_q[wptr2_q] <= din2_i;
    end

    assign req1_o      = req1;
    assign req2_o      = req2;
    assign full1_o     = full1;
    assign full2_o     = full2;
    assign cnt1_o      = cnt1_q;
    assign cnt2_o      = cnt2_q;
    assign out_valid_o = out_valid_q;
    assign out_src_o   = out_src_q;
    assign out_data_o  = out_data_q;
    assign ovf_o       = ovf_q;
    assign perr_o      = perr_q;

endmodule

// File: tb/tb_arb2_req_fifo.sv
module tb_arb2_req_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          push1_i = 1'b0, push2_i = 1'b0;
    logic [DW-1:0] din1_i = '0, din2_i = '0;
    logic          gnt1_i = 1'b0, gnt2_i = 1'b0;
    logic          full1_o, full2_o, req1_o, req2_o;
    logic          out_valid_o, out_src_o, ovf_o, perr_o;
    logic [DW-1:0] out_data_o;
    logic [CW-1:0] cnt1_o, cnt2_o;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    arb2_req_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .push1_i(push1_i), .din1_i(din1_i), .full1_o(full1_o),
        .push2_i(push2_i), .din2_i(din2_i), .full2_o(full2_o),
        .req1_o(req1_o), .req2_o(req2_o), .gnt1_i(gnt1_i), .gnt2_i(gnt2_i),
        .out_valid_o(out_valid_o), .out_src_o(out_src_o), .out_data_o(out_data_o),
        .cnt1_o(cnt1_o), .cnt2_o(cnt2_o), .ovf_o(ovf_o), .perr_o(perr_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: two queues plus flags ----------------
    logic [DW-1:0] q1[$], q2[$];
    logic          m_vld = 1'b0, m_src = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;
    logic [DW-1:0] m_dat = '0;

    always @(posedge clk) begin
        bit r1, r2, f1, f2, p1, p2;
        if (rst_i) begin
            q1.delete(); q2.delete();
            m_vld = 1'b0; m_src = 1'b0; m_dat = '0; m_ovf = 1'b0; m_perr = 1'b0;
        end else begin
            r1 = (q1.size() != 0);
            r2 = (q2.size() != 0);
            f1 = (q1.size() == DEPTH);
            f2 = (q2.size() == DEPTH);
            p1 = gnt1_i && r1;
            p2 = gnt2_i && !gnt1_i && r2;
            if ((gnt1_i && !r1) || (gnt2_i && !r2) || (gnt1_i && gnt2_i)) m_perr = 1'b1;
            m_vld = p1 || p2;
            if (p1) begin m_dat = q1.pop_front(); m_src = 1'b0; end
            else if (p2) begin m_dat = q2.pop_front(); m_src = 1'b1; end
            if (push1_i) begin if (f1) m_ovf = 1'b1; else q1.push_back(din1_i); end
            if (push2_i) begin if (f2) m_ovf = 1'b1; else q2.push_back(din2_i); end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    logic [DW:0] olog[$];   // {src, data} of every output pulse

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req1", req1_o, q1.size() != 0);
            chk("req2", req2_o, q2.size() != 0);
            chk("full1", full1_o, q1.size() == DEPTH);
            chk("full2", full2_o, q2.size() == DEPTH);
            chk("cnt1", cnt1_o, q1.size());
            chk("cnt2", cnt2_o, q2.size());
            chk("ovf", ovf_o, m_ovf);
            chk("perr", perr_o, m_perr);
            chk("out_valid", out_valid_o, m_vld);
            chk("out_src", out_src_o, m_src);
            chk("out_data", out_data_o, m_dat);
            if (out_valid_o === 1'b1) olog.push_back({out_src_o, out_data_o});
        end
    end

    // Apply inputs for one edge; returns just after the following falling edge.
    task automatic drive(input logic p1, input logic [DW-1:0] d1,
                         input logic p2, input logic [DW-1:0] d2,
                         input logic g1, input logic g2);
        push1_i = p1; din1_i = d1; push2_i = p2; din2_i = d2;
        gnt1_i = g1; gnt2_i = g2;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Combinational 2-way round-robin arbiter driven from the DUT requests.
    bit rr_last = 1'b1;   // 1: client 2 granted last, so client 1 goes next
    task automatic arb_cycle();
        logic g1, g2;
        g1 = 1'b0; g2 = 1'b0;
        if (req1_o && req2_o) begin
            if (rr_last) g1 = 1'b1; else g2 = 1'b1;
        end else if (req1_o) g1 = 1'b1;
        else if (req2_o) g2 = 1'b1;
        if (g1) rr_last = 1'b0;
        if (g2) rr_last = 1'b1;
        drive(1'b0, '0, 1'b0, '0, g1, g2);
    endtask

    initial begin
        logic [DW:0] exp3 [3];
        logic [DW:0] exp4 [4];
        logic [DW:0] exp6 [6];
        int n_arb;

        // Reset held two cycles while both clients push.
        rst_i = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0, 1'b0);
        chk("rst_cnt1", cnt1_o, 0);
        chk("rst_req2", req2_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_data", out_data_o, 0);
        rst_i = 1'b0;
        idle();

        // Single client, granted whenever it requests.
        olog.delete();
        drive(1'b1, 8'h11, 1'b0, '0, req1_o, 1'b0);
        drive(1'b1, 8'h22, 1'b0, '0, req1_o, 1'b0);
        drive(1'b1, 8'h33, 1'b0, '0, req1_o, 1'b0);
        drive(1'b0, '0, 1'b0, '0, req1_o, 1'b0);
        idle();
        exp3 = '{9'h011, 9'h022, 9'h033};
        chk("single_npulse", olog.size(), 3);
        for (int i = 0; i < 3; i++) chk("single_word", olog[i], exp3[i]);
        chk("single_req1", req1_o, 0);
        chk("single_cnt1", cnt1_o, 0);

        // Fill client 2 past capacity, then drain.
        for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        chk("fill_cnt2", cnt2_o, 4);
        chk("fill_full2", full2_o, 1);
        chk("fill_ovf", ovf_o, 1);
        olog.delete();
        for (int i = 0; i < 10 && req2_o; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        exp4 = '{9'h1C0, 9'h1C1, 9'h1C2, 9'h1C3};
        chk("drain_npulse", olog.size(), 4);
        for (int i = 0; i < 4; i++) chk("drain_word", olog[i], exp4[i]);

        rst_i = 1'b1; idle(); rst_i = 1'b0;
        chk("rst2_ovf", ovf_o, 0);

        // Arbiter in the loop with both clients loaded.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        olog.delete();
        rr_last = 1'b1;
        n_arb = 0;
        for (int i = 0; i < 12 && (req1_o || req2_o); i++) begin arb_cycle(); n_arb++; end
        idle();
        exp6 = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1, 9'h0A2, 9'h1B2};
        chk("arb_cycles", n_arb, 6);
        chk("arb_npulse", olog.size(), 6);
        for (int i = 0; i < 6; i++) chk("arb_word", olog[i], exp6[i]);
        chk("arb_perr", perr_o, 0);

        // Simultaneous push and pop on client 1 holding two words.
        drive(1'b1, 8'h55, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b0, '0, 1'b0, 1'b0);
        chk("sim_cnt1_pre", cnt1_o, 2);
        olog.delete();
        drive(1'b1, 8'h44, 1'b0, '0, 1'b1, 1'b0);
        chk("sim_cnt1", cnt1_o, 2);
        chk("sim_head", olog.size() > 0 ? olog[0] : 9'h1FF, 9'h055);

        // Protocol errors.
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("perr_empty_valid", out_valid_o, 0);
        chk("perr_empty", perr_o, 1);
        drive(1'b0, '0, 1'b1, 8'h77, 1'b0, 1'b0);
        olog.delete();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        chk("both_cnt2", cnt2_o, 1);
        chk("both_cnt1", cnt1_o, 1);
        chk("both_word", olog.size() > 0 ? olog[0] : 9'h1FF, 9'h066);
        idle(); idle();
        chk("perr_sticky", perr_o, 1);
        rst_i = 1'b1; idle(); rst_i = 1'b0;
        chk("perr_rst", perr_o, 0);

        // Push into a full FIFO is dropped even with a pop on the same edge.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hD0 + i), 1'b0, '0, 1'b0, 1'b0);
        chk("full1", full1_o, 1);
        drive(1'b1, 8'hEE, 1'b0, '0, 1'b1, 1'b0);
        chk("fullpop_cnt1", cnt1_o, 3);
        chk("fullpop_ovf", ovf_o, 1);
        olog.delete();
        for (int i = 0; i < 10 && req1_o; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("fullpop_npulse", olog.size(), 3);
        chk("fullpop_last", olog.size() == 3 ? olog[2] : 9'h1FF, 9'h0D3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
